// File: rtl/oven_cycle_ctrl.sv
// oven_cycle_ctrl: sequencer for one bake cycle of the oven simulator.
// It accepts a setpoint and cook time, then runs the cycle: preheat ramp,
// timed cook with heater regulation, end-of-cycle alarm, and a return to idle.
// It owns the simulated oven temperature and remaining-time registers. The
// sequencer advances only on the 1 Hz tick enable.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   tick                one-cycle enable, once per second
//   start, cancel       one-cycle begin / abort requests
//   pause               level input, holds the cycle while high
//   set_temp, set_time  setpoint (degrees) and cook time (seconds)
//   oven_temp           simulated oven temperature (registered)
//   time_left           cook seconds remaining (registered)
//   state               IDLE=0, PREHEAT=1, COOK=2, PAUSE=3, ALARM=4
//   heater_on, alarm    heater command, end-of-cycle buzzer
//   done, err           one-cycle pulses: cook expired / start rejected
//   busy                high whenever state is not IDLE
module oven_cycle_ctrl #(
  parameter int DATA_W      = 10,
  parameter int AMBIENT     = 70,
  parameter int MAX_TEMP    = 500,
  parameter int RAMP_STEP   = 25,
  parameter int COOL_STEP   = 10,
  parameter int ALARM_TICKS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              cancel,
  input  logic              pause,
  input  logic [DATA_W-1:0] set_temp,
  input  logic [DATA_W-1:0] set_time,
  output logic [DATA_W-1:0] oven_temp,
  output logic [DATA_W-1:0] time_left,
  output logic [2:0]        state,
  output logic              heater_on,
  output logic              alarm,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int CW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREHEAT = 3'd1,
    S_COOK    = 3'd2,
    S_PAUSE   = 3'd3,
    S_ALARM   = 3'd4
  } state_t;

  state_t            state_r, state_n;
  state_t            saved_r, saved_n;
  logic [DATA_W-1:0] setpoint_r, setpoint_n;
  logic [DATA_W-1:0] temp_n, time_n;
  logic [CW-1:0]     cnt_r, cnt_n;
  logic              done_n, err_n, heater_n, alarm_n, busy_n;
  logic [DATA_W-1:0] heat_t, cool_t, reg_t;
  logic              start_ok;

  // Rise by RAMP_STEP in one extra bit so the sum cannot wrap, clamped at sp.
  function automatic logic [DATA_W-1:0] heat_step(input logic [DATA_W-1:0] t,
                                                  input logic [DATA_W-1:0] sp);
    logic [DATA_W:0] sum;
    sum = {1'b0, t} + (DATA_W+1)'(RAMP_STEP);
    if (sum >= {1'b0, sp}) heat_step = sp;
    else                   heat_step = sum[DATA_W-1:0];
  endfunction

  // Fall by COOL_STEP, never below the ambient floor.
  function automatic logic [DATA_W-1:0] cool_step(input logic [DATA_W-1:0] t);
    logic [DATA_W:0] limit;
    limit = (DATA_W+1)'(AMBIENT) + (DATA_W+1)'(COOL_STEP);
    if ({1'b0, t} <= limit) cool_step = DATA_W'(AMBIENT);
    else                    cool_step = t - DATA_W'(COOL_STEP);
  endfunction

  assign heat_t   = heat_step(oven_temp, setpoint_r);
  assign cool_t   = cool_step(oven_temp);
  assign reg_t    = (oven_temp < setpoint_r) ? heat_t : cool_t;
  assign start_ok = (set_temp > DATA_W'(AMBIENT)) && (set_temp <= DATA_W'(MAX_TEMP)) &&
                    (set_time != '0);
  assign state    = state_r;

  always_comb begin
    state_n    = state_r;
    saved_n    = saved_r;
    setpoint_n = setpoint_r;
    temp_n     = oven_temp;
    time_n     = time_left;
    cnt_n      = cnt_r;
    done_n     = 1'b0;
    err_n      = 1'b0;
    if (cancel && (state_r != S_IDLE)) begin
      // Abort: temperature holds this cycle and cools from there in IDLE.
      state_n = S_IDLE;
      time_n  = '0;
    end else begin
      unique case (state_r)
        S_IDLE: begin
          // A cancel in the same cycle suppresses the start entirely.
          if (start && !cancel && start_ok) begin
            setpoint_n = set_temp;
            time_n     = set_time;
            state_n    = S_PREHEAT;
          end else begin
            if (start && !cancel) err_n = 1'b1;
            if (tick) temp_n = cool_t;
          end
        end
        S_PREHEAT: begin
          if (tick) begin
            temp_n = heat_t;
            if (heat_t == setpoint_r) state_n = S_COOK;
          end
          // A coincident tick has already picked the state to resume into.
          if (pause) begin
            saved_n = (tick && (heat_t == setpoint_r)) ? S_COOK : S_PREHEAT;
            state_n = S_PAUSE;
          end
        end
        S_COOK: begin
          if (tick) begin
            temp_n = reg_t;
            time_n = time_left - 1'b1;
            if (time_left == DATA_W'(1)) begin
              done_n  = 1'b1;
              cnt_n   = '0;
              state_n = S_ALARM;
            end
          end
          // Expiry on the same tick finishes the cycle instead of pausing it.
          if (pause && !(tick && (time_left == DATA_W'(1)))) begin
            saved_n = S_COOK;
            state_n = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (tick)   temp_n  = cool_t;
          if (!pause) state_n = saved_r;
        end
        S_ALARM: begin
          if (tick) begin
            temp_n = cool_t;
            if (cnt_r == CW'(ALARM_TICKS - 1)) state_n = S_IDLE;
            else                               cnt_n   = cnt_r + 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    // Flags are derived from the next state so they register alongside it.
    heater_n = (state_n == S_PREHEAT) || ((state_n == S_COOK) && (temp_n < setpoint_n));
    alarm_n  = (state_n == S_ALARM);
    busy_n   = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      saved_r    <= S_PREHEAT;
      setpoint_r <= '0;
      oven_temp  <= DATA_W'(AMBIENT);
      time_left  <= '0;
      cnt_r      <= '0;
      heater_on  <= 1'b0;
      alarm      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_n;
      saved_r    <= saved_n;
      setpoint_r <= setpoint_n;
      oven_temp  <= temp_n;
      time_left  <= time_n;
      cnt_r      <= cnt_n;
      heater_on  <= heater_n;
      alarm      <= alarm_n;
      done       <= done_n;
      err        <= err_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_oven_cycle_ctrl.sv
// Testbench for oven_cycle_ctrl: directed scenarios followed by randomized
// traffic, checked by a scoreboard fed from a behavioural oven model.
module tb_oven_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick, start, cancel, pause;
  logic [9:0] set_temp, set_time;
  logic [9:0] oven_temp, time_left;
  logic [2:0] state;
  logic       heater_on, alarm, done, err, busy;

  always #5 clk = ~clk;

  oven_cycle_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .cancel(cancel),
    .pause(pause), .set_temp(set_temp), .set_time(set_time),
    .oven_temp(oven_temp), .time_left(time_left), .state(state),
    .heater_on(heater_on), .alarm(alarm), .done(done), .err(err), .busy(busy)
  );

  typedef struct packed {
    logic [9:0] temp;
    logic [9:0] left;
    logic [2:0] st;
    logic       heater;
    logic       alrm;
    logic       dn;
    logic       er;
    logic       bsy;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural oven: mode numbers are the externally visible state codes.
  int m_mode = 0, m_temp = 70, m_left = 0, m_sp = 0, m_resume = 1;
  int m_beeps_left = 0;
  bit m_done = 0, m_err = 0;

  function automatic int heat(int t, int sp);
    return (t + 25 < sp) ? t + 25 : sp;
  endfunction

  function automatic int cool(int t);
    return (t - 10 > 70) ? t - 10 : 70;
  endfunction

  task automatic model_step(bit r, bit tk, bit st, bit cn, bit ps, int stemp, int stime);
    bit finished;
    finished = 0;
    m_done   = 0;
    m_err    = 0;
    if (r) begin
      m_mode = 0; m_temp = 70; m_left = 0; m_sp = 0; m_resume = 1; m_beeps_left = 0;
    end else if (cn && m_mode != 0) begin
      m_mode = 0;
      m_left = 0;
    end else begin
      case (m_mode)
        0: begin
          if (st && !cn && stemp > 70 && stemp <= 500 && stime != 0) begin
            m_sp = stemp; m_left = stime; m_mode = 1;
          end else begin
            if (st && !cn) m_err = 1;
            if (tk) m_temp = cool(m_temp);
          end
        end
        1: begin
          if (tk) begin
            m_temp = heat(m_temp, m_sp);
            if (m_temp == m_sp) m_mode = 2;
          end
          if (ps) begin m_resume = m_mode; m_mode = 3; end
        end
        2: begin
          if (tk) begin
            m_temp = (m_temp < m_sp) ? heat(m_temp, m_sp) : cool(m_temp);
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_done = 1; m_mode = 4; m_beeps_left = 5; finished = 1;
            end
          end
          if (ps && !finished) begin m_resume = 2; m_mode = 3; end
        end
        3: begin
          if (tk) m_temp = cool(m_temp);
          if (!ps) m_mode = m_resume;
        end
        4: begin
          if (tk) begin
            m_temp = cool(m_temp);
            m_beeps_left = m_beeps_left - 1;
            if (m_beeps_left == 0) m_mode = 0;
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.temp   = 10'(m_temp);
    o.left   = 10'(m_left);
    o.st     = 3'(m_mode);
    o.heater = (m_mode == 1) || (m_mode == 2 && m_temp < m_sp);
    o.alrm   = (m_mode == 4);
    o.dn     = m_done;
    o.er     = m_err;
    o.bsy    = (m_mode != 0);
    return o;
  endfunction

  // One clock of stimulus; the model's view of the following cycle is queued.
  task automatic cyc(bit r, bit tk, bit st, bit cn, bit ps, int stemp, int stime);
    @(negedge clk);
    reset = r; tick = tk; start = st; cancel = cn; pause = ps;
    set_temp = 10'(stemp); set_time = 10'(stime);
    @(posedge clk);
    #1;
    model_step(r, tk, st, cn, ps, stemp, stime);
    q.push_back(model_obs());
  endtask

  task automatic idle(bit ps);
    cyc(0, 0, 0, 0, ps, 0, 0);
  endtask

  task automatic ticks(int n, bit ps);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0, ps, 0, 0);
      idle(ps);
    end
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every registered output vector is compared against the queue.
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        g = {oven_temp, time_left, state, heater_on, alarm, done, err, busy};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got temp=%0d left=%0d st=%0d htr=%b alm=%b dn=%b er=%b bsy=%b, expected temp=%0d left=%0d st=%0d htr=%b alm=%b dn=%b er=%b bsy=%b",
                   $time, g.temp, g.left, g.st, g.heater, g.alrm, g.dn, g.er, g.bsy,
                   e.temp, e.left, e.st, e.heater, e.alrm, e.dn, e.er, e.bsy);
        end
      end
    end
  end

  initial begin
    bit p;
    bit tk;
    int stemp;
    reset = 1; tick = 0; start = 0; cancel = 0; pause = 0; set_temp = 0; set_time = 0;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("reset_state", state, 0);
    chk("reset_temp", oven_temp, 70);
    chk("reset_busy", busy, 0);

    // Nominal cycle 150 degrees for 3 seconds.
    cyc(0, 0, 1, 0, 0, 150, 3);
    chk("start_state", state, 1);
    chk("start_left", time_left, 3);
    chk("start_heater", heater_on, 1);
    ticks(3, 0);
    chk("preheat_temp3", oven_temp, 145);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("preheat_temp4", oven_temp, 150);
    chk("cook_entry_state", state, 2);
    idle(0);
    ticks(2, 0);
    chk("cook_left1", time_left, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("done_pulse", done, 1);
    chk("alarm_state", state, 4);
    chk("alarm_on", alarm, 1);
    chk("alarm_temp", oven_temp, 140);
    idle(0);
    chk("done_cleared", done, 0);
    ticks(4, 0);
    chk("alarm_held", alarm, 1);
    ticks(1, 0);
    chk("alarm_end_state", state, 0);
    chk("alarm_end_temp", oven_temp, 90);

    // Rejected starts.
    cyc(0, 0, 1, 0, 0, 60, 10);
    chk("rej_low_err", err, 1);
    idle(0);
    cyc(0, 0, 1, 0, 0, 600, 10);
    chk("rej_high_err", err, 1);
    idle(0);
    cyc(0, 0, 1, 0, 0, 150, 0);
    chk("rej_time_err", err, 1);
    chk("rej_busy", busy, 0);
    idle(0);

    // Pause during cook at time_left=5 (temperature starts at 90).
    cyc(0, 0, 1, 0, 0, 150, 5);
    ticks(3, 0);
    chk("pause_pre_state", state, 2);
    idle(1);
    chk("pause_state", state, 3);
    ticks(3, 1);
    chk("pause_temp", oven_temp, 120);
    chk("pause_left", time_left, 5);
    chk("pause_heater", heater_on, 0);
    idle(0);
    chk("resume_state", state, 2);
    chk("resume_heater", heater_on, 1);
    ticks(1, 0);
    chk("resume_temp", oven_temp, 145);
    chk("resume_left", time_left, 4);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("cancel_cook_state", state, 0);

    // Cancel together with a tick in preheat at 120 degrees.
    ticks(10, 0);
    cyc(0, 0, 1, 0, 0, 200, 5);
    ticks(2, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("cancel_tick_state", state, 0);
    chk("cancel_tick_left", time_left, 0);
    chk("cancel_tick_temp", oven_temp, 120);

    // Cancel and start together in idle.
    cyc(0, 0, 1, 1, 0, 200, 5);
    chk("cancel_start_state", state, 0);
    chk("cancel_start_err", err, 0);

    // Reset mid-cook with a coincident tick.
    cyc(0, 0, 1, 0, 0, 95, 9);
    ticks(2, 0);
    chk("midcook_state", state, 2);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rst_temp", oven_temp, 70);
    chk("rst_left", time_left, 0);
    chk("rst_state", state, 0);
    chk("rst_flags", {heater_on, alarm, done, err, busy}, 0);

    // Randomized traffic; pause only changes level on cycles without a tick.
    p = 0;
    for (int i = 0; i < 4000; i++) begin
      tk = ($urandom_range(0, 2) == 0);
      if (!tk && $urandom_range(0, 40) == 0) p = !p;
      stemp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1023))
                                          : int'($urandom_range(71, 500));
      cyc(($urandom_range(0, 700) == 0), tk, ($urandom_range(0, 14) == 0),
          ($urandom_range(0, 80) == 0), p, stemp, int'($urandom_range(0, 12)));
    end

    idle(0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
